// File: rtl/ps2_key_fifo.sv
// PS/2 key byte FIFO with a 16-bit status/data word for MCU port 4.
// Defining PS2_KEY_FIFO_IRQ_EN builds a registered non-empty interrupt request.
module ps2_key_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  key_data,
  input  logic        key_strobe,
  input  logic        pop_toggle,
  input  logic        flush_toggle,
  output logic [15:0] port_word,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic                  strobe_q;
  logic [2:0]            pop_sync_q;
  logic [2:0]            flush_sync_q;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic push_evt, pop_evt, flush_evt;
  logic full, empty;
  logic do_push, do_pop;

  // Toggle inputs come from the slower MCU clock: two sync flops, then a history flop.
  assign pop_evt   = pop_sync_q[1] ^ pop_sync_q[2];
  assign flush_evt = flush_sync_q[1] ^ flush_sync_q[2];
  assign push_evt  = key_strobe & ~strobe_q & (key_data != 8'h00);

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    do_pop   = ~flush_evt & pop_evt & ~empty;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    do_push  = ~flush_evt & push_evt & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush_evt) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(do_push);
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (push_evt && full && !do_pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q     <= 1'b0;
      pop_sync_q   <= '0;
      flush_sync_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      strobe_q     <= key_strobe;
      pop_sync_q   <= {pop_sync_q[1:0], pop_toggle};
      flush_sync_q <= {flush_sync_q[1:0], flush_toggle};
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      if (do_push) mem_q[wr_ptr_q] <= key_data;
    end
  end

  assign port_word = {~empty, ovf_q, 2'b00, 4'(count_q),
                      empty ? 8'h00 : mem_q[rd_ptr_q]};

`ifdef PS2_KEY_FIFO_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= (count_d != '0);
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: push, pop, flush, overflow and reset corners.
module tb_ps2_key_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  key_data = 8'h00;
  logic        key_strobe = 1'b0;
  logic        pop_toggle = 1'b0;
  logic        flush_toggle = 1'b0;
  logic [15:0] port_word;
  logic        irq;

`ifdef PS2_KEY_FIFO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  ps2_key_fifo #(.DEPTH_LOG2(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_data     (key_data),
    .key_strobe   (key_strobe),
    .pop_toggle   (pop_toggle),
    .flush_toggle (flush_toggle),
    .port_word    (port_word),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic check_irq(input string tag, input bit pending);
    check(tag, {15'b0, irq}, {15'b0, IRQ_EN & pending});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    key_data   = b;
    key_strobe = 1'b1;
    tick();
    key_strobe = 1'b0;
    tick();
  endtask

  task automatic pop_once();
    pop_toggle = ~pop_toggle;
    tick();
    tick();
    tick();
  endtask

  initial begin
    // Reset
    repeat (2) tick();
    check("reset_word", port_word, 16'h0000);
    check_irq("reset_irq", 1'b0);
    reset_n = 1'b1;
    tick();

    // Single push
    push_byte(8'h41);
    check("push_41", port_word, 16'h8141);
    check_irq("irq_after_push", 1'b1);
    pop_once();
    check("pop_to_empty", port_word, 16'h0000);
    check_irq("irq_after_pop", 1'b0);

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) push_byte(8'h31 + 8'(i));
    check("full_8", port_word, 16'h8831);
    push_byte(8'h39);
    check("overflow", port_word, 16'hC831);
    // Pop latency: head must not move before the third edge
    pop_toggle = ~pop_toggle;
    tick();
    tick();
    check("pop_lat_e1", port_word, 16'hC831);
    tick();
    check("pop_lat_e2", port_word, 16'hC732);
    for (int k = 2; k <= 7; k++) begin
      pop_once();
      check("drain", port_word, 16'hC000 | (16'(8 - k) << 8) | 16'(8'h31 + 8'(k)));
    end
    pop_once();
    check("drained_ovf_kept", port_word, 16'h4000);
    flush_toggle = ~flush_toggle;
    repeat (3) tick();
    check("flush_clears_ovf", port_word, 16'h0000);

    // Full FIFO, push on the same edge as a pop
    for (int i = 0; i < 8; i++) push_byte(8'h61 + 8'(i));
    check("full_61", port_word, 16'h8861);
    pop_toggle = ~pop_toggle;
    tick();
    tick();
    key_data   = 8'h5A;
    key_strobe = 1'b1;
    tick();
    check("pop_push_full", port_word, 16'h8862);
    key_strobe = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) pop_once();
    check("before_last", port_word, 16'h8268);
    pop_once();
    check("last_is_5A", port_word, 16'h815A);
    pop_once();
    check("empty_no_ovf", port_word, 16'h0000);

    // Held strobe and zero byte
    key_data   = 8'h77;
    key_strobe = 1'b1;
    repeat (100) tick();
    check("held_strobe", port_word, 16'h8177);
    key_strobe = 1'b0;
    tick();
    push_byte(8'h00);
    check("zero_byte", port_word, 16'h8177);

    // Three bytes with overflow, then flush racing a push
    for (int i = 0; i < 7; i++) push_byte(8'h71 + 8'(i));
    check("full_77", port_word, 16'h8877);
    push_byte(8'h7F);
    check("overflow_2", port_word, 16'hC877);
    for (int k = 0; k < 5; k++) pop_once();
    check("three_left", port_word, 16'hC375);
    flush_toggle = ~flush_toggle;
    tick();
    tick();
    key_data   = 8'h55;
    key_strobe = 1'b1;
    tick();
    check("flush_beats_push", port_word, 16'h0000);
    check_irq("irq_after_flush", 1'b0);
    key_strobe = 1'b0;
    tick();
    check("flush_stable", port_word, 16'h0000);

    // Reset mid-operation, with pop_toggle high at release
    push_byte(8'h21);
    push_byte(8'h22);
    check("pre_reset", port_word, 16'h8221);
    pop_toggle = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    check("async_reset", port_word, 16'h0000);
    check_irq("irq_in_reset", 1'b0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("spurious_pop", port_word, 16'h0000);
    check_irq("irq_spurious", 1'b0);
    push_byte(8'h42);
    check("push_after_reset", port_word, 16'h8142);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
